// File: rtl/mips_multicycle_ctrl_if.sv
// Control/handshake bundle between the multi-cycle controller (master) and the shared
// MIPS datapath plus unified memory port (slave).
interface mips_multicycle_ctrl_if;
   logic [31:0] instr;
   logic        alu_zero;
   logic        mem_ack;
   logic        mem_req;
   logic        mem_we;
   logic        iord;
   logic        ir_write;
   logic        pc_write;
   logic        pc_src;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic [31:0] alu_instr;
   logic        reg_write;
   logic        reg_dst;
   logic        mem_to_reg;
   logic        instr_done;
   logic        err;

   modport master (
      input  instr, alu_zero, mem_ack,
      output mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
             alu_instr, reg_write, reg_dst, mem_to_reg, instr_done, err
   );

   modport slave (
      output instr, alu_zero, mem_ack,
      input  mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
             alu_instr, reg_write, reg_dst, mem_to_reg, instr_done, err
   );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: fetch/decode/exec/mem/writeback sequencing with a
// req/ack memory handshake, memory timeout and a sticky error state.
module mips_multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   mips_multicycle_ctrl_if.master bus
);
   localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [31:0] ALU_ADDU = 32'h0000_0021;

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, ERROR} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [5:0] opcode, funct;
   logic       is_rtype, r_legal, is_imm, is_br, is_lw, is_sw, legal;

   logic        mem_req_c, mem_we_c, iord_c, ir_write_c, pc_write_c, pc_src_c;
   logic        alu_src_a_c, reg_write_c, reg_dst_c, mem_to_reg_c, instr_done_c, err_c;
   logic [1:0]  alu_src_b_c;
   logic [31:0] alu_instr_c;

   assign opcode   = bus.instr[31:26];
   assign funct    = bus.instr[5:0];
   assign is_rtype = (opcode == 6'h00);
   assign r_legal  = (funct == 6'h21) || (funct == 6'h23) || (funct == 6'h27) ||
                     (funct == 6'h00) || (funct == 6'h02);
   assign is_imm   = (opcode == 6'h09) || (opcode == 6'h0C);
   assign is_br    = (opcode == 6'h04) || (opcode == 6'h05);
   assign is_lw    = (opcode == 6'h23);
   assign is_sw    = (opcode == 6'h2B);
   assign legal    = (is_rtype && r_legal) || is_imm || is_br || is_lw || is_sw;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      mem_req_c    = 1'b0;
      mem_we_c     = 1'b0;
      iord_c       = 1'b0;
      ir_write_c   = 1'b0;
      pc_write_c   = 1'b0;
      pc_src_c     = 1'b0;
      alu_src_a_c  = 1'b0;
      alu_src_b_c  = 2'd0;
      alu_instr_c  = '0;
      reg_write_c  = 1'b0;
      reg_dst_c    = 1'b0;
      mem_to_reg_c = 1'b0;
      instr_done_c = 1'b0;
      err_c        = 1'b0;

      case (state_q)
         FETCH: begin
            mem_req_c   = 1'b1;
            alu_src_b_c = 2'd1;
            alu_instr_c = ALU_ADDU;
            if (bus.mem_ack) begin
               ir_write_c = 1'b1;
               pc_write_c = 1'b1;
               state_d    = DECODE;
            end else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
               state_d = ERROR;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DECODE: begin
            alu_src_b_c = 2'd3;
            alu_instr_c = ALU_ADDU;
            state_d     = legal ? EXEC : ERROR;
         end
         EXEC: begin
            alu_instr_c = bus.instr;
            alu_src_a_c = 1'b1;
            if (is_rtype) begin
               state_d = WB;
            end else if (is_imm) begin
               alu_src_b_c = 2'd2;
               state_d     = WB;
            end else if (is_lw || is_sw) begin
               alu_src_b_c = 2'd2;
               state_d     = MEM;
            end else if (is_br) begin
               // bne's ALU op reports equality inverted, so zero means taken for both
               pc_write_c   = bus.alu_zero;
               pc_src_c     = bus.alu_zero;
               instr_done_c = 1'b1;
               state_d      = FETCH;
            end else begin
               state_d = ERROR;
            end
         end
         MEM: begin
            mem_req_c = 1'b1;
            iord_c    = 1'b1;
            mem_we_c  = is_sw;
            if (bus.mem_ack) begin
               instr_done_c = is_sw;
               state_d      = is_sw ? FETCH : WB;
            end else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
               state_d = ERROR;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         WB: begin
            reg_write_c  = 1'b1;
            reg_dst_c    = is_rtype;
            mem_to_reg_c = is_lw;
            instr_done_c = 1'b1;
            state_d      = FETCH;
         end
         ERROR: err_c = 1'b1;
         default: state_d = ERROR;
      endcase

      // Clearing on every state change covers entry into both FETCH and MEM
      if (state_d != state_q) cnt_d = '0;
   end

   // Reset gates the outputs directly so a pending request drops without waiting for a clock
   assign bus.mem_req    = rst_n & mem_req_c;
   assign bus.mem_we     = rst_n & mem_we_c;
   assign bus.iord       = rst_n & iord_c;
   assign bus.ir_write   = rst_n & ir_write_c;
   assign bus.pc_write   = rst_n & pc_write_c;
   assign bus.pc_src     = rst_n & pc_src_c;
   assign bus.alu_src_a  = rst_n & alu_src_a_c;
   assign bus.alu_src_b  = rst_n ? alu_src_b_c : 2'd0;
   assign bus.alu_instr  = rst_n ? alu_instr_c : '0;
   assign bus.reg_write  = rst_n & reg_write_c;
   assign bus.reg_dst    = rst_n & reg_dst_c;
   assign bus.mem_to_reg = rst_n & mem_to_reg_c;
   assign bus.instr_done = rst_n & instr_done_c;
   assign bus.err        = rst_n & err_c;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Cycle-accurate check of mips_multicycle_ctrl against an instruction-level trace model
// that expands each instruction class into its expected per-cycle control vector.
module tb_mips_multicycle_ctrl;
   localparam int TMO = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mips_multicycle_ctrl_if bus ();

   mips_multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [45:0] obs;
   assign obs = {bus.mem_req, bus.mem_we, bus.iord, bus.ir_write, bus.pc_write, bus.pc_src,
                 bus.alu_src_a, bus.alu_src_b, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
                 bus.instr_done, bus.err, bus.alu_instr};

   typedef struct {
      logic        ack;
      logic        zero;
      logic [31:0] ins;
      logic [45:0] exp;
   } ent_t;

   ent_t tr[$];
   int   n_cmp = 0;
   int   n_mis = 0;

   function automatic logic [45:0] ov(input logic req, we, io, irw, pcw, pcs, sa,
                                      input logic [1:0] sb, input logic rw, rd, m2r, dn, er,
                                      input logic [31:0] ai);
      return {req, we, io, irw, pcw, pcs, sa, sb, rw, rd, m2r, dn, er, ai};
   endfunction

   function automatic logic rb();
      return logic'($urandom_range(0, 1));
   endfunction

   // k: 0..4 R-type (addu subu nor sll srl), 5 addiu, 6 andi, 7 beq, 8 bne, 9 lw, 10 sw
   function automatic logic [31:0] rand_instr(input int k);
      logic [25:0] f;
      logic [5:0]  fn;
      f = 26'($urandom);
      case (k)
         0: fn = 6'h21;
         1: fn = 6'h23;
         2: fn = 6'h27;
         3: fn = 6'h00;
         default: fn = 6'h02;
      endcase
      case (k)
         5:  return {6'h09, f};
         6:  return {6'h0C, f};
         7:  return {6'h04, f};
         8:  return {6'h05, f};
         9:  return {6'h23, f};
         10: return {6'h2B, f};
         default: return {6'h00, f[25:6], fn};
      endcase
   endfunction

   task automatic push(input logic a, input logic z, input logic [31:0] ins, input logic [45:0] e);
      ent_t t;
      t.ack = a; t.zero = z; t.ins = ins; t.exp = e;
      tr.push_back(t);
   endtask

   task automatic push_err(input int n, input logic [31:0] ins);
      for (int i = 0; i < n; i++)
         push(rb(), rb(), ins, ov(0,0,0,0,0,0,0,2'd0,0,0,0,0,1,32'h0));
   endtask

   // k = 11 marks an illegal encoding; fd/md = wait cycles before ack in fetch / memory
   task automatic add_instr(input int k, input logic [31:0] ins, input int fd, input int md,
                            input logic z);
      logic r, im, br, lw, sw;
      r = (k <= 4); im = (k == 5 || k == 6); br = (k == 7 || k == 8);
      lw = (k == 9); sw = (k == 10);
      for (int c = 0; c < fd && c < TMO; c++)
         push(1'b0, rb(), ins, ov(1,0,0,0,0,0,0,2'd1,0,0,0,0,0,32'h21));
      if (fd >= TMO) begin push_err(4, ins); return; end
      push(1'b1, rb(), ins, ov(1,0,0,1,1,0,0,2'd1,0,0,0,0,0,32'h21));
      push(rb(), rb(), ins, ov(0,0,0,0,0,0,0,2'd3,0,0,0,0,0,32'h21));
      if (k == 11) begin push_err(5, ins); return; end
      if (br) begin
         push(rb(), z, ins, ov(0,0,0,0,z,z,1,2'd0,0,0,0,1,0,ins));
         return;
      end
      push(rb(), rb(), ins, ov(0,0,0,0,0,0,1,(r ? 2'd0 : 2'd2),0,0,0,0,0,ins));
      if (lw || sw) begin
         for (int c = 0; c < md && c < TMO; c++)
            push(1'b0, rb(), ins, ov(1,sw,1,0,0,0,0,2'd0,0,0,0,0,0,32'h0));
         if (md >= TMO) begin push_err(4, ins); return; end
         push(1'b1, rb(), ins, ov(1,sw,1,0,0,0,0,2'd0,0,0,0,sw,0,32'h0));
         if (sw) return;
      end
      if (r || im || lw)
         push(rb(), rb(), ins, ov(0,0,0,0,0,0,0,2'd0,1,r,lw,1,0,32'h0));
   endtask

   // Entered and left at a falling edge; n < 0 runs the whole queued trace
   task automatic run_trace(input string name, input int n);
      int cnt;
      ent_t e;
      cnt = (n < 0) ? tr.size() : n;
      for (int i = 0; i < cnt; i++) begin
         e = tr.pop_front();
         bus.mem_ack  = e.ack;
         bus.alu_zero = e.zero;
         bus.instr    = e.ins;
         #1;
         n_cmp++;
         if (obs !== e.exp) begin
            n_mis++;
            $display("FAIL %s cyc%0d: got %h expected %h", name, i, obs, e.exp);
         end
         @(negedge clk);
      end
   endtask

   task automatic do_reset(input string name);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (obs !== 46'h0) begin
         n_mis++;
         $display("FAIL %s_asserted: got %h expected %h", name, obs, 46'h0);
      end
      bus.mem_ack = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (obs !== ov(1,0,0,0,0,0,0,2'd1,0,0,0,0,0,32'h21)) begin
         n_mis++;
         $display("FAIL %s_released: got %h expected %h", name, obs,
                  ov(1,0,0,0,0,0,0,2'd1,0,0,0,0,0,32'h21));
      end
   endtask

   task automatic test_reset();
      do_reset("reset");
   endtask

   task automatic test_addu();
      add_instr(0, 32'h0022_1821, 0, 0, 1'b0);
      run_trace("addu", -1);
   endtask

   task automatic test_lw();
      add_instr(9, 32'h8C22_0004, 3, 3, 1'b0);
      run_trace("lw_delayed", -1);
   endtask

   task automatic test_branch();
      add_instr(7, 32'h1022_0003, 0, 0, 1'b1);
      add_instr(7, 32'h1022_0003, 1, 0, 1'b0);
      add_instr(8, 32'h1422_0003, 0, 0, 1'b1);
      add_instr(8, 32'h1422_0003, 2, 0, 1'b0);
      add_instr(0, 32'h0022_1821, 0, 0, 1'b0);
      run_trace("branch", -1);
   endtask

   task automatic test_illegal();
      add_instr(11, 32'hFC00_0000, 0, 0, 1'b0);
      run_trace("illegal_opcode", -1);
      do_reset("illegal_opcode_rst");
      add_instr(11, 32'h0022_1820, 1, 0, 1'b0);
      run_trace("illegal_funct", -1);
      do_reset("illegal_funct_rst");
   endtask

   task automatic test_timeout();
      add_instr(0, 32'h0022_1821, TMO, 0, 1'b0);
      run_trace("fetch_timeout", -1);
      do_reset("fetch_timeout_rst");
      add_instr(0, 32'h0022_1821, TMO - 1, 0, 1'b0);
      add_instr(9, 32'h8C22_0004, 0, TMO - 1, 1'b0);
      add_instr(10, 32'hAC22_0008, 0, TMO, 1'b0);
      run_trace("mem_timeout", -1);
      do_reset("mem_timeout_rst");
   endtask

   task automatic test_reset_mid_mem();
      add_instr(10, 32'hAC22_0008, 0, 3, 1'b0);
      run_trace("sw_pre_reset", 4);
      tr.delete();
      #1;
      n_cmp++;
      if ({bus.mem_req, bus.mem_we} !== 2'b11) begin
         n_mis++;
         $display("FAIL sw_mem_hold: got %b expected %b", {bus.mem_req, bus.mem_we}, 2'b11);
      end
      do_reset("reset_mid_mem");
      add_instr(0, 32'h0022_1821, 0, 0, 1'b0);
      run_trace("after_mid_reset", -1);
   endtask

   task automatic test_back_to_back();
      int k;
      for (int i = 0; i < 80; i++) begin
         k = $urandom_range(0, 10);
         add_instr(k, rand_instr(k), $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1), rb());
      end
      run_trace("random", -1);
   endtask

   initial begin
      bus.mem_ack  = 1'b0;
      bus.alu_zero = 1'b0;
      bus.instr    = '0;
      @(negedge clk);
      test_reset();
      test_addu();
      test_lw();
      test_branch();
      test_illegal();
      test_timeout();
      test_reset_mid_mem();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
